// File: rtl/neopixel_frame_ctrl_if.sv
// neopixel_frame_ctrl_if
//   Groups the byte-stream input and the pixel handshake of neopixel_frame_ctrl.
//   slave  : controller side (consumes rx bytes and px_busy, drives pixel/status outputs)
//   master : environment side (UART receiver + serializer)
// Signals:
//   rx_byte[7:0]  received UART byte
//   rx_valid      one-cycle strobe, rx_byte valid
//   px_busy       serializer busy
//   px_valid      pixel request to serializer
//   px_r/g/b[7:0] colour of the current pixel
//   frame_done    pulse after the last pixel of a frame has finished
//   load_done     pulse after the last byte of the last pixel is written
interface neopixel_frame_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       px_busy;
  logic       px_valid;
  logic [7:0] px_r;
  logic [7:0] px_g;
  logic [7:0] px_b;
  logic       frame_done;
  logic       load_done;

  modport master (
    output rx_byte, rx_valid, px_busy,
    input  px_valid, px_r, px_g, px_b, frame_done, load_done
  );

  modport slave (
    input  rx_byte, rx_valid, px_busy,
    output px_valid, px_r, px_g, px_b, frame_done, load_done
  );
endinterface

// File: rtl/neopixel_frame_ctrl.sv
// neopixel_frame_ctrl
//   NUM_PIXELS-deep RGB frame buffer loaded from a UART byte stream (R, G, B per pixel),
//   streamed periodically to the writepixel serializer, one pixel per handshake.
// Ports:
//   CLK     system clock
//   RST_N   asynchronous active-low reset
//   io_bus  neopixel_frame_ctrl_if.slave (rx_byte/rx_valid in, px_busy in,
//           px_valid/px_r/px_g/px_b/frame_done/load_done out)
// Optional feature:
//   NEOPIXEL_LOAD_TIMEOUT_EN - when defined, an inter-byte gap of TIMEOUT_CYCLES realigns the
//   loader to R of pixel 0.
module neopixel_frame_ctrl #(
  parameter int unsigned NUM_PIXELS     = 10,
  parameter int unsigned REFRESH_CYCLES = 2097152,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input logic                  CLK,
  input logic                  RST_N,
  neopixel_frame_ctrl_if.slave io_bus
);

  localparam int unsigned PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_CYCLES - 1);

  if (NUM_PIXELS < 1 || NUM_PIXELS > 256 || REFRESH_CYCLES < 2 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("neopixel_frame_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StWait} state_e;

  // Frame buffer: not reset, so a reset never wipes the displayed image.
  logic [7:0] r_mem_r [NUM_PIXELS];
  logic [7:0] r_mem_g [NUM_PIXELS];
  logic [7:0] r_mem_b [NUM_PIXELS];

  // Loader
  logic [1:0]       r_ld_byte;
  logic [PIX_W-1:0] r_ld_pix;
  logic             r_load_done;
  logic [1:0]       w_wr_byte;  // effective byte slot for this cycle
  logic [PIX_W-1:0] w_wr_pix;   // effective pixel slot for this cycle

  // Refresh FSM
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PIX_W-1:0] r_pix;
  logic             r_px_valid;
  logic [7:0]       r_px_r;
  logic [7:0]       r_px_g;
  logic [7:0]       r_px_b;
  logic             r_frame_done;

`ifdef NEOPIXEL_LOAD_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES);

  logic [GAP_W-1:0] r_gap;
  logic             w_gap_sat;

  assign w_gap_sat = (r_gap == GAP_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gap <= '0;
    end else if (io_bus.rx_valid) begin
      r_gap <= '0;
    end else if (!w_gap_sat) begin
      r_gap <= r_gap + 1'b1;
    end
  end

  // A saturated gap makes the next byte land on R of pixel 0.
  assign w_wr_byte = w_gap_sat ? 2'd0 : r_ld_byte;
  assign w_wr_pix  = w_gap_sat ? '0 : r_ld_pix;
`else
  assign w_wr_byte = r_ld_byte;
  assign w_wr_pix  = r_ld_pix;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ld_byte   <= 2'd0;
      r_ld_pix    <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      if (io_bus.rx_valid) begin
        if (w_wr_byte == 2'd2) begin
          r_ld_byte   <= 2'd0;
          r_ld_pix    <= (w_wr_pix == LAST_PIX) ? '0 : w_wr_pix + 1'b1;
          r_load_done <= (w_wr_pix == LAST_PIX);
        end else begin
          r_ld_byte <= w_wr_byte + 1'b1;
          r_ld_pix  <= w_wr_pix;
        end
      end else begin
        r_ld_byte <= w_wr_byte;
        r_ld_pix  <= w_wr_pix;
      end
    end
  end

  // Writes and the FETCH read share an edge, so a same-slot read sees the old value.
  always_ff @(posedge CLK) begin
    if (io_bus.rx_valid) begin
      case (w_wr_byte)
        2'd0:    r_mem_r[w_wr_pix] <= io_bus.rx_byte;
        2'd1:    r_mem_g[w_wr_pix] <= io_bus.rx_byte;
        default: r_mem_b[w_wr_pix] <= io_bus.rx_byte;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_pix        <= '0;
      r_px_valid   <= 1'b0;
      r_px_r       <= 8'd0;
      r_px_g       <= 8'd0;
      r_px_b       <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_pix   <= '0;
            r_state <= StFetch;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StFetch: begin
          r_px_r     <= r_mem_r[r_pix];
          r_px_g     <= r_mem_g[r_pix];
          r_px_b     <= r_mem_b[r_pix];
          r_px_valid <= 1'b1;
          r_state    <= StSend;
        end
        StSend: begin
          // Busy seen means the serializer took the pixel; valid drops on this edge.
          if (io_bus.px_busy) begin
            r_px_valid <= 1'b0;
            r_state    <= StWait;
          end
        end
        StWait: begin
          if (!io_bus.px_busy) begin
            if (r_pix == LAST_PIX) begin
              r_frame_done <= 1'b1;
              r_state      <= StIdle;
            end else begin
              r_pix   <= r_pix + 1'b1;
              r_state <= StFetch;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.px_valid   = r_px_valid;
  assign io_bus.px_r       = r_px_r;
  assign io_bus.px_g       = r_px_g;
  assign io_bus.px_b       = r_px_b;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.load_done  = r_load_done;

endmodule
